// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - RISC-V immediate decoder feeding a 2-entry skid FIFO
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  entry_t          dec_entry;

  entry_t          mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            live;
  logic            push;
  logic            pop;
  entry_t          head;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Opcode-driven immediate extraction; the decode happens before the FIFO so
  // the head entry is ready to drive outputs straight from registers.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
          else            dec_imm = XLEN'(in_instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_IMM32: begin
        // Word-sized immediates only exist on the 64-bit datapath.
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(in_instr[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_instr[31:20]));
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_OP32: begin
        if (XLEN != 64) dec_illegal = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt = FMT_ZIMM;
          dec_imm = XLEN'(in_instr[19:15]);
        end
      end
      OP_OP, OP_FENCE: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_entry = '{instr: in_instr, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

  // Flush wins over both handshakes so nothing from that cycle survives.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      live   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Saturating tally of illegal instructions actually handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (pop && head.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign in_ready  = live && (count != 2'd2);

  // Outputs read as zero whenever no entry is presented.
  always_comb begin
    out_instr   = '0;
    out_imm     = '0;
    out_fmt     = FMT_NONE;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_instr   = head.instr;
      out_imm     = head.imm;
      out_fmt     = head.fmt;
      out_illegal = head.illegal;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized and directed bench for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  illegal_cnt;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_instr_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [15:0] illegal_cnt_b;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .illegal_cnt(illegal_cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32;
    logic [2:0]  fmt64;
    logic        ill32;
    logic        ill64;
  } ent_t;

  ent_t q[$];
  bit   live = 0;
  int   c32 = 0;
  int   c64 = 0;
  int   pops = 0;

  function automatic longint sx(input longint unsigned x, input int bits);
    longint r;
    r = longint'(x);
    if (x[bits-1]) r = r - (longint'(1) << bits);
    return r;
  endfunction

  // Reference decode from the instruction-set field layouts, using shifts and masks.
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output longint v, output int f, output bit il);
    longint unsigned u;
    longint unsigned op, f3;
    u  = 64'(ins);
    op = u & 127;
    f3 = (u >> 12) & 7;
    v = 0; f = 0; il = 0;
    case (op)
      'h13: if (f3 == 1 || f3 == 5) begin
              f = 6; v = (xlen == 64) ? longint'((u >> 20) & 63) : longint'((u >> 20) & 31);
            end else begin f = 1; v = sx((u >> 20) & 4095, 12); end
      'h03, 'h67: begin f = 1; v = sx((u >> 20) & 4095, 12); end
      'h1B: if (xlen != 64) il = 1;
            else if (f3 == 1 || f3 == 5) begin f = 6; v = longint'((u >> 20) & 31); end
            else begin f = 1; v = sx((u >> 20) & 4095, 12); end
      'h3B: if (xlen != 64) il = 1;
      'h23: begin f = 2; v = sx((((u >> 25) & 127) << 5) | ((u >> 7) & 31), 12); end
      'h63: begin f = 3; v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                                 (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13); end
      'h6F: begin f = 5; v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                                 (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21); end
      'h37, 'h17: begin f = 4; v = sx(u & 64'hFFFFF000, 32); end
      'h73: if (f3 >= 4) begin f = 7; v = longint'((u >> 15) & 31); end
      'h33, 'h0F: ;
      default: il = 1;
    endcase
  endfunction

  function automatic ent_t mk(input logic [31:0] ins);
    ent_t e; longint v; int f; bit il;
    e.instr = ins;
    ref_dec(ins, 32, v, f, il);
    e.imm32 = {32'd0, v[31:0]}; e.fmt32 = f[2:0]; e.ill32 = il;
    ref_dec(ins, 64, v, f, il);
    e.imm64 = v; e.fmt64 = f[2:0]; e.ill64 = il;
    return e;
  endfunction

  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    ent_t h; bit push, pop;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    #1;
    h = '{instr: 0, imm32: 0, imm64: 0, fmt32: 0, fmt64: 0, ill32: 0, ill64: 0};
    if (q.size() > 0) h = q[0];
    check("in_ready", in_ready, live && q.size() < 2);
    check("in_ready64", in_ready_b, live && q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    check("out_valid64", out_valid_b, q.size() > 0);
    check("out_instr", out_instr, h.instr);
    check("out_instr64", out_instr_b, h.instr);
    check("out_imm", out_imm, h.imm32);
    check("out_imm64", out_imm_b, h.imm64);
    check("out_fmt", out_fmt, h.fmt32);
    check("out_fmt64", out_fmt_b, h.fmt64);
    check("out_illegal", out_illegal, h.ill32);
    check("out_illegal64", out_illegal_b, h.ill64);
    check("illegal_cnt", illegal_cnt, c32);
    check("illegal_cnt64", illegal_cnt_b, c64);
    push = v && live && q.size() < 2;
    pop  = rdy && q.size() > 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) begin
        if (h.ill32) c32 = (c32 == 3) ? 3 : c32 + 1;
        if (h.ill64) c64 = (c64 == 65535) ? 65535 : c64 + 1;
        void'(q.pop_front());
        pops++;
      end
      if (push) q.push_back(mk(ins));
    end
    live = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    check("rst_illegal_cnt64", illegal_cnt_b, 0);
    check("rst_out_imm64", out_imm_b, 0);
    q.delete(); c32 = 0; c64 = 0; live = 0;
    in_valid = 0; out_ready = 0; flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    live = 1;
    #1;
    check("rel_in_ready", in_ready, 1);
  endtask

  // Push one instruction into an empty stage and compare against fixed answers.
  task automatic directed(input logic [31:0] ins, input logic [2:0] fmt,
                          input logic [31:0] imm32, input logic [63:0] imm64, input bit ill);
    step(1, ins, 0, 0);
    #2;
    check("dir_fmt", out_fmt, fmt);
    check("dir_imm", out_imm, imm32);
    check("dir_imm64", out_imm_b, imm64);
    check("dir_ill", out_illegal, ill);
    step(0, 0, 1, 0);
  endtask

  logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37,
                           7'h17, 7'h1B, 7'h3B, 7'h73, 7'h33, 7'h0F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  initial begin
    int p0;
    do_reset();

    directed(32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
    directed(32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
    directed(32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 0);
    directed(32'h01F09093, 3'd6, 32'h0000001F, 64'h000000000000001F, 0);
    directed(32'h0052D073, 3'd7, 32'h00000005, 64'h0000000000000005, 0);
    directed(32'h00000000, 3'd0, 32'h00000000, 64'h0, 1);
    #2 check("dir_cnt_after_pop", illegal_cnt, 1);

    // Backpressure: third push must be refused while two entries wait.
    p0 = pops;
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    step(1, 32'h00300193, 0, 0);
    #2 check("bp_in_ready", in_ready, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("bp_pops", pops - p0, 2);

    // Full-rate streaming.
    p0 = pops;
    for (int i = 0; i < 100; i++) step(1, rand_instr(), 1, 0);
    step(0, 0, 1, 0);
    check("stream_pops", pops - p0, 100);

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h00000000, 1, 0);
    step(0, 0, 1, 0);
    #2 check("sat_cnt", illegal_cnt, 3);
    check("sat_cnt64", illegal_cnt_b, 5);

    // Flush with two entries plus a same-cycle push, then with one entry and an accepted push.
    step(1, 32'h00000013, 0, 0);
    step(1, 32'h00000000, 0, 0);
    step(1, 32'h00000000, 1, 1);
    #2 check("flush_out_valid", out_valid, 0);
    step(1, 32'h00000000, 0, 0);
    step(1, 32'h00000017, 1, 1);
    #2 check("flush2_out_valid", out_valid, 0);
    step(0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);

    // Reset in the middle of traffic.
    step(1, 32'hFFFFFFFF, 0, 0);
    step(1, 32'h00000000, 0, 0);
    do_reset();
    for (int i = 0; i < 50; i++)
      step($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
